// File: rtl/module_keypad_scanner.sv
// Matrix keypad scanner: walks an active-low column strobe, debounces press and release, and holds one key code until acknowledged.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module module_keypad_scanner #(
    parameter int N_COLS       = 4,
    parameter int N_ROWS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int REPEAT_CYC   = 25000000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_ROWS-1:0]                   row,
    output logic [N_COLS-1:0]                   col,
    output logic [$clog2(N_ROWS*N_COLS)-1:0]    key_code,
    output logic                                key_valid,
    input  logic                                key_ack
);

    localparam int CIDX_W = $clog2(N_COLS);
    localparam int RIDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int KC_W   = $clog2(N_ROWS*N_COLS);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    if (N_COLS < 2 || N_ROWS < 1 || SCAN_DIV < 2 || DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
        $error("module_keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    state_t              state_q;
    logic [CIDX_W-1:0]   col_idx_q;
    logic [N_COLS-1:0]   col_q;
    logic [RIDX_W-1:0]   row_idx_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [DEB_W-1:0]    deb_cnt_q;
    logic [KC_W-1:0]     key_code_q;
    logic                key_valid_q;

    logic [CIDX_W-1:0]   col_idx_d;
    logic [N_COLS-1:0]   col_adv_d;
    logic [RIDX_W-1:0]   row_idx_d;
    logic [KC_W-1:0]     key_code_d;
    logic                row_any_low;
    logic                row_sel;
    logic                dwell_end;
    logic                deb_done;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    logic [REP_W-1:0]    rep_cnt_q;
`endif

    function automatic logic [N_COLS-1:0] col_drive(input logic [CIDX_W-1:0] idx);
        col_drive = ~({{(N_COLS-1){1'b0}}, 1'b1} << idx);
    endfunction

    always_comb begin
        col_idx_d = (col_idx_q == CIDX_W'(N_COLS-1)) ? '0 : col_idx_q + 1'b1;
        col_adv_d = col_drive(col_idx_d);
        // Descending scan so the lowest-index closed row wins.
        row_idx_d = '0;
        for (int i = N_ROWS-1; i >= 0; i--) begin
            if (!row[i]) begin
                row_idx_d = RIDX_W'(i);
            end
        end
        row_any_low = ~&row;
        row_sel     = row[row_idx_q];
        dwell_end   = (div_cnt_q == DIV_W'(SCAN_DIV-1));
        deb_done    = (deb_cnt_q == DEB_W'(DEBOUNCE_CYC-1));
        key_code_d  = KC_W'(row_idx_q) * KC_W'(N_COLS) + KC_W'(col_idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= '0;
            col_q       <= col_drive('0);
            row_idx_q   <= '0;
            div_cnt_q   <= '0;
            deb_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (dwell_end) begin
                        div_cnt_q <= '0;
                        deb_cnt_q <= '0;
                        if (row_any_low) begin
                            row_idx_q <= row_idx_d;
                            state_q   <= ST_DEBOUNCE;
                        end else begin
                            col_idx_q <= col_idx_d;
                            col_q     <= col_adv_d;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!row_sel) begin
                        if (deb_done) begin
                            deb_cnt_q <= '0;
                            state_q   <= ST_PRESSED;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        // Bounce: drop the candidate and move on to the next column.
                        deb_cnt_q <= '0;
                        div_cnt_q <= '0;
                        col_idx_q <= col_idx_d;
                        col_q     <= col_adv_d;
                        state_q   <= ST_SCAN;
                    end
                end

                ST_PRESSED: begin
                    if (!key_valid_q) begin
                        key_code_q  <= key_code_d;
                        key_valid_q <= 1'b1;
                    end else if (key_ack) begin
                        key_valid_q <= 1'b0;
                        deb_cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_q   <= '0;
`endif
                        state_q     <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
`ifdef KEYPAD_REPEAT_EN
                    if (key_valid_q) begin
                        if (key_ack) begin
                            key_valid_q <= 1'b0;
                            rep_cnt_q   <= '0;
                        end
                    end else if (row_sel) begin
                        rep_cnt_q <= '0;
                        if (deb_done) begin
                            deb_cnt_q <= '0;
                            div_cnt_q <= '0;
                            col_idx_q <= col_idx_d;
                            col_q     <= col_adv_d;
                            state_q   <= ST_SCAN;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        // Key still held: count toward the next repeat of the same code.
                        deb_cnt_q <= '0;
                        if (rep_cnt_q == REP_W'(REPEAT_CYC-1)) begin
                            rep_cnt_q   <= '0;
                            key_valid_q <= 1'b1;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + 1'b1;
                        end
                    end
`else
                    if (row_sel) begin
                        if (deb_done) begin
                            deb_cnt_q <= '0;
                            div_cnt_q <= '0;
                            col_idx_q <= col_idx_d;
                            col_q     <= col_adv_d;
                            state_q   <= ST_SCAN;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        deb_cnt_q <= '0;
                    end
`endif
                end

                default: begin
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Scenario bench for module_keypad_scanner at N_COLS=4, N_ROWS=4, SCAN_DIV=2, DEBOUNCE_CYC=4, REPEAT_CYC=20.
module tb_module_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_ack = 1'b0;
    logic [3:0] row = 4'hF;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    module_keypad_scanner #(
        .N_COLS(4),
        .N_ROWS(4),
        .SCAN_DIV(2),
        .DEBOUNCE_CYC(4),
        .REPEAT_CYC(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ack(key_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns on the first cycle of a fresh dwell on column pattern c.
    task automatic wait_col(input logic [3:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && col === c; i++) tick();
        for (int i = 0; i < 20 && col !== c; i++) tick();
        ok = (col === c);
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        row   = 4'hF;
        tick(); tick(); tick();
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b, expected %b", col, 4'b1110); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d, expected 0", key_code); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] seq [8];
        seq = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (col !== seq[i]) begin errors++; $display("FAIL idle_col[%0d]: got %b, expected %b", i, col, seq[i]); end
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b, expected 0", i, key_valid); end
        end
    endtask

    task automatic test_press_hold();
        bit ok;
        int n;
        logic [3:0] exp;
        wait_col(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL press_wait_col: got %b, expected %b", col, 4'b1011); end
        row = 4'b1011;
        exp_q.push_back(4'd10);
        n = 0;
        while (key_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
            // Stray acknowledges before a key is pending must be ignored.
            key_ack = (n >= 2 && n <= 4);
            if (key_valid !== 1'b1) begin
                checks++; if (col !== 4'b1011) begin errors++; $display("FAIL press_col_frozen[%0d]: got %b, expected %b", n, col, 4'b1011); end
            end
        end
        key_ack = 1'b0;
        checks++; if (n != 7) begin errors++; $display("FAIL press_latency: got %0d cycles, expected 7", n); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL press_scoreboard: got empty queue, expected one entry"); end
        else begin
            exp = exp_q.pop_front();
            if (key_code !== exp) begin errors++; $display("FAIL press_code: got %0d, expected %0d", key_code, exp); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            row = 4'hF;
            checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_hold_valid[%0d]: got %b, expected 1", i, key_valid); end
            checks++; if (key_code !== 4'd10) begin errors++; $display("FAIL press_hold_code[%0d]: got %0d, expected 10", i, key_code); end
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_ack_clear: got %b, expected 0", key_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (col !== 4'b1011) begin errors++; $display("FAIL release_col_frozen[%0d]: got %b, expected %b", i, col, 4'b1011); end
        end
        tick();
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL release_resume: got %b, expected %b", col, 4'b0111); end
    endtask

    task automatic test_glitch();
        bit ok;
        bit seen;
        wait_col(4'b1101, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_wait_col: got %b, expected %b", col, 4'b1101); end
        row = 4'b1101;
        tick(); tick();
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL glitch_col_frozen: got %b, expected %b", col, 4'b1101); end
        row = 4'hF;
        tick();
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL glitch_next_col: got %b, expected %b", col, 4'b1011); end
        tick(); tick();
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL glitch_scan_resume: got %b, expected %b", col, 4'b0111); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (key_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_no_valid: got %b, expected 0", seen); end
    endtask

    task automatic test_back_to_back_ack();
        bit ok;
        int n;
        logic [3:0] exp;
        wait_col(4'b1110, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ack_wait_col: got %b, expected %b", col, 4'b1110); end
        row = 4'b1101;
        exp_q.push_back(4'd4);
        wait_valid(20, n);
        checks++; if (n != 7) begin errors++; $display("FAIL ack_latency: got %0d cycles, expected 7", n); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ack_scoreboard: got empty queue, expected one entry"); end
        else begin
            exp = exp_q.pop_front();
            if (key_code !== exp) begin errors++; $display("FAIL ack_code: got %0d, expected %0d", key_code, exp); end
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        row = 4'hF;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b, expected 0", key_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (col !== 4'b1110) begin errors++; $display("FAIL ack_col_frozen[%0d]: got %b, expected %b", i, col, 4'b1110); end
        end
        tick();
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL ack_resume: got %b, expected %b", col, 4'b1101); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        logic [3:0] exp;
        wait_col(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstdeb_wait_col: got %b, expected %b", col, 4'b1011); end
        row = 4'b0111;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        row   = 4'hF;
        tick();
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rstdeb_col: got %b, expected %b", col, 4'b1110); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstdeb_valid: got %b, expected 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL rstdeb_code: got %0d, expected 0", key_code); end
        rst_n = 1'b1;
        tick();
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rst_restart_col0: got %b, expected %b", col, 4'b1110); end
        tick();
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL rst_restart_col1: got %b, expected %b", col, 4'b1101); end

        wait_col(4'b0111, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstprs_wait_col: got %b, expected %b", col, 4'b0111); end
        row = 4'b0111;
        exp_q.push_back(4'd15);
        wait_valid(20, n);
        checks++; if (n != 7) begin errors++; $display("FAIL rstprs_latency: got %0d cycles, expected 7", n); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rstprs_scoreboard: got empty queue, expected one entry"); end
        else begin
            exp = exp_q.pop_front();
            if (key_code !== exp) begin errors++; $display("FAIL rstprs_code: got %0d, expected %0d", key_code, exp); end
        end
        tick();
        rst_n = 1'b0;
        row   = 4'hF;
        tick();
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rstprs_col: got %b, expected %b", col, 4'b1110); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstprs_valid: got %b, expected 0", key_valid); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL rstprs_code_clr: got %0d, expected 0", key_code); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_repeat();
        bit ok;
        int n;
        logic [3:0] exp;
        wait_col(4'b1011, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rep_wait_col: got %b, expected %b", col, 4'b1011); end
        row = 4'b1110;
        exp_q.push_back(4'd2);
        wait_valid(20, n);
        checks++; if (n != 7) begin errors++; $display("FAIL rep_latency: got %0d cycles, expected 7", n); end
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rep_scoreboard: got empty queue, expected one entry"); end
        else begin
            exp = exp_q.pop_front();
            if (key_code !== exp) begin errors++; $display("FAIL rep_code: got %0d, expected %0d", key_code, exp); end
        end
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rep_first_ack: got %b, expected 0", key_valid); end
`ifdef KEYPAD_REPEAT_EN
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back(4'd2);
            wait_valid(40, n);
            checks++; if (n != 20) begin errors++; $display("FAIL rep_period[%0d]: got %0d cycles, expected 20", p, n); end
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rep_scoreboard[%0d]: got empty queue, expected one entry", p); end
            else begin
                exp = exp_q.pop_front();
                if (key_code !== exp) begin errors++; $display("FAIL rep_code[%0d]: got %0d, expected %0d", p, key_code, exp); end
            end
            key_ack = 1'b1;
            tick();
            key_ack = 1'b0;
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rep_ack[%0d]: got %b, expected 0", p, key_valid); end
        end
`else
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (key_valid === 1'b1) seen = 1'b1;
            end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rep_single_pulse: got %b, expected 0", seen); end
        end
`endif
        row = 4'hF;
        tick(); tick(); tick(); tick();
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL rep_resume: got %b, expected %b", col, 4'b0111); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_hold();
        test_glitch();
        test_back_to_back_ack();
        test_reset_mid();
        test_repeat();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/module_keypad_scanner.md
MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Interface
REQ-001 Parameter N_COLS, default 4: number of keypad columns driven, >= 2.
REQ-002 Parameter N_ROWS, default 4: number of keypad rows sensed, >= 1.
REQ-003 Parameter SCAN_DIV, default 50000: clock cycles each column stays driven, >= 2.
REQ-004 Parameter DEBOUNCE_CYC, default 500000: consecutive stable cycles to accept a press or release, >= 1.
REQ-005 Parameter REPEAT_CYC, default 25000000: auto-repeat interval in cycles; used only under KEYPAD_REPEAT_EN.
REQ-006 clk  input  1  the single clock; every state element is clocked on its rising edge.
REQ-007 rst_n  input  1  reset; synchronous and active-low.
REQ-008 row  input  N_ROWS  row sense lines; active-low (0 = key closed); already synchronised upstream.
REQ-009 col  output  N_COLS  column drive; one-hot active-low, exactly one bit 0 at all times.
REQ-010 key_code  output  $clog2(N_ROWS*N_COLS)  index of the accepted key, equal to row_idx*N_COLS + col_idx.
REQ-011 key_valid  output  1  key_code holds a new key; held high until acknowledged.
REQ-012 key_ack  input  1  consumer acknowledge; consumes key_valid when both are high on the same rising edge.

Function
REQ-013 The FSM SHALL have four states: SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-014 SCAN: col SHALL advance to the next index every SCAN_DIV cycles, wrapping from N_COLS-1 to 0.
REQ-015 SCAN: row SHALL be sampled only on the last cycle of each dwell. If any bit is 0, the FSM SHALL latch col_idx and the lowest-index low row, freeze col, and enter DEBOUNCE.
REQ-016 DEBOUNCE: if the latched row reads 0 for DEBOUNCE_CYC consecutive cycles, the FSM SHALL enter PRESSED. If it reads 1 on any cycle first, the FSM SHALL return to SCAN, advance col and assert no key_valid.
REQ-017 PRESSED entry: key_code SHALL be registered and key_valid SHALL rise on the cycle after debounce completes, so press-accept latency is DEBOUNCE_CYC+1 cycles from the scan sample.
REQ-018 key_valid and key_code SHALL stay stable until a cycle with key_valid=1 and key_ack=1. key_valid SHALL be 0 on the following cycle, and the FSM SHALL then enter RELEASE.
REQ-019 key_ack while key_valid=0 SHALL be ignored.
REQ-020 A physical release while key_valid is pending SHALL NOT clear key_valid or alter key_code.
REQ-021 RELEASE: after the latched row reads 1 for DEBOUNCE_CYC consecutive cycles, the FSM SHALL return to SCAN with col advanced by one. Any 0 SHALL restart the count.
REQ-022 Other keys pressed during DEBOUNCE, PRESSED or RELEASE SHALL be ignored.
REQ-023 Counters SHALL be sized $clog2 of the largest count they hold and SHALL never wrap silently.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL set: state SCAN, col index 0 (col = all ones except bit 0), all counters 0, key_code 0, key_valid 0.
REQ-025 Reset asserted in any state SHALL abandon a pending key without an acknowledge.
REQ-026 Scanning SHALL restart at column 0 on the first cycle with rst_n=1.

Configuration
REQ-027 Macro KEYPAD_REPEAT_EN defined: while in RELEASE with the key still held, key_valid SHALL re-assert with the same key_code every REPEAT_CYC cycles after the previous acknowledge. The handshake of REQ-018 SHALL apply to each repeat.
REQ-028 KEYPAD_REPEAT_EN undefined: one key_valid SHALL be produced per press, REQ-021 applies unchanged, and no repeat logic is synthesised.

Verification (N_COLS=4, N_ROWS=4, SCAN_DIV=2, DEBOUNCE_CYC=4, REPEAT_CYC=20)
REQ-029 Idle, row=4'b1111 -> col cycles 1110,1101,1011,0111,1110, changing every 2 clocks, with key_valid=0 throughout.
REQ-030 Hold row[2]=0 while col=1011 -> col freezes, key_valid=1 with key_code=10 on the 5th cycle after the sample, held until key_ack.
REQ-031 Row[1] low for 2 cycles only -> no key_valid, and scanning resumes at the next column.
REQ-032 Press, ack on the same cycle valid rises, release -> key_valid high exactly 1 cycle, then scanning resumes 4 cycles after release.
REQ-033 Assert rst_n=0 mid-DEBOUNCE and mid-PRESSED -> next cycle col=1110, key_valid=0, key_code=0.
REQ-034 KEYPAD_REPEAT_EN defined, key held, each valid acked immediately -> key_valid re-pulses every 20 cycles with an identical key_code. Undefined -> a single pulse only.
